// File: rtl/pll_phase_meter_pkg.sv
// Shared definitions for the PLL phase meter: FSM encodings and the default
// no-signal timeout derived from the clock rate and the slowest expected reference.
`timescale 1ns/1ps
package pll_phase_meter_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int CLK_HZ          = 50_000_000;
    localparam int REF_MIN_HZ      = 50_000;
    localparam int TIMEOUT_PERIODS = 5;
    localparam int DEFAULT_TIMEOUT = CLK_HZ / REF_MIN_HZ * TIMEOUT_PERIODS;

endpackage

// File: rtl/pll_phase_meter_edge_sync.sv
// Brings an asynchronous square wave into the clk_50 domain and flags its rising edges.
// The rise flag is registered so both meter inputs see identical, fixed latency.
`timescale 1ns/1ps
module edge_sync
    import pll_phase_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;
    logic                   rise_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = din;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/pll_phase_meter.sv
// Measures the averaged reference period and the ref->sig rising-edge offset in clk_50
// cycles, publishing one result per averaging window and flagging missing inputs.
`timescale 1ns/1ps
module pll_phase_meter
    import pll_phase_meter_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             ref_in,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] phase,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             sig_lost
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0]    CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [AVG_LOG2-1:0] N_LAST       = '1;

    generate
        if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
            $error("pll_phase_meter: TIMEOUT must lie in 1 .. 2**CNT_W-1");
        end
        if (SYNC_STAGES < 2 || AVG_LOG2 < 1) begin : g_bad_params
            $error("pll_phase_meter: need SYNC_STAGES >= 2 and AVG_LOG2 >= 1");
        end
    endgenerate

    logic ref_rise;
    logic sig_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .din    (ref_in),
        .rise   (ref_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .din    (sig_in),
        .rise   (sig_rise)
    );

    logic [0:0]          state_reg,      state_next;
    logic [CNT_W-1:0]    period_ctr_reg, period_ctr_next;
    logic [CNT_W-1:0]    phase_ctr_reg,  phase_ctr_next;
    logic [CNT_W-1:0]    phase_lat_reg,  phase_lat_next;
    logic [AVG_LOG2-1:0] n_reg,          n_next;
    logic [ACC_W-1:0]    acc_reg,        acc_next;
    logic                armed_reg,      armed_next;
    logic                seen_reg,       seen_next;
    // Window results are staged for one cycle so meas_valid and the outputs move together.
    logic                done_reg,       done_next;
    logic [ACC_W-1:0]    sum_reg,        sum_next;
    logic [CNT_W-1:0]    pend_phase_reg, pend_phase_next;
    logic                pend_seen_reg,  pend_seen_next;
    logic [CNT_W-1:0]    period_reg,     period_next;
    logic [CNT_W-1:0]    phase_reg,      phase_next;
    logic                meas_valid_reg, meas_valid_next;
    logic                no_signal_reg,  no_signal_next;
    logic                sig_lost_reg,   sig_lost_next;

    logic [CNT_W-1:0] period_inc;
    logic [CNT_W-1:0] phase_inc;
    logic             timeout_hit;

    assign period_inc = (period_ctr_reg == CNT_MAX) ? CNT_MAX : period_ctr_reg + 1'b1;
    assign phase_inc  = (phase_ctr_reg == CNT_MAX) ? CNT_MAX : phase_ctr_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        period_ctr_next = period_ctr_reg;
        phase_ctr_next  = phase_ctr_reg;
        phase_lat_next  = phase_lat_reg;
        n_next          = n_reg;
        acc_next        = acc_reg;
        armed_next      = armed_reg;
        seen_next       = seen_reg;
        done_next       = 1'b0;
        sum_next        = sum_reg;
        pend_phase_next = pend_phase_reg;
        pend_seen_next  = pend_seen_reg;
        period_next     = period_reg;
        phase_next      = phase_reg;
        meas_valid_next = 1'b0;
        no_signal_next  = no_signal_reg;
        sig_lost_next   = sig_lost_reg;
        timeout_hit     = 1'b0;

        if (done_reg) begin
            period_next     = CNT_W'(sum_reg >> AVG_LOG2);
            if (pend_seen_reg) begin
                phase_next = pend_phase_reg;
            end
            sig_lost_next   = ~pend_seen_reg;
            no_signal_next  = 1'b0;
            meas_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (ref_rise) begin
                    state_next      = RUN;
                    period_ctr_next = '0;
                    phase_ctr_next  = '0;
                    armed_next      = 1'b1;
                    n_next          = '0;
                    acc_next        = '0;
                    seen_next       = 1'b0;
                end
            end
            RUN: begin
                period_ctr_next = period_inc;
                phase_ctr_next  = phase_inc;
                if (ref_rise) begin
                    period_ctr_next = '0;
                    phase_ctr_next  = '0;
                    armed_next      = 1'b1;
                    if (n_reg == N_LAST) begin
                        sum_next        = acc_reg + ACC_W'(period_inc);
                        pend_phase_next = phase_lat_reg;
                        pend_seen_next  = seen_reg;
                        done_next       = 1'b1;
                        acc_next        = '0;
                        n_next          = '0;
                        seen_next       = 1'b0;
                    end else begin
                        acc_next = acc_reg + ACC_W'(period_inc);
                        n_next   = n_reg + 1'b1;
                    end
                end else if (period_ctr_reg == TIMEOUT_LAST) begin
                    // Reference vanished: drop the partial window and report no signal.
                    timeout_hit    = 1'b1;
                    state_next     = IDLE;
                    no_signal_next = 1'b1;
                    period_next    = '0;
                    sig_lost_next  = 1'b1;
                    armed_next     = 1'b0;
                    seen_next      = 1'b0;
                    n_next         = '0;
                    acc_next       = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // A sig edge coinciding with a ref edge belongs to the period that edge opens.
        if (sig_rise && !timeout_hit && (ref_rise || (state_reg == RUN && armed_reg))) begin
            phase_lat_next = ref_rise ? '0 : phase_inc;
            seen_next      = 1'b1;
            armed_next     = 1'b0;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            period_ctr_reg <= '0;
            phase_ctr_reg  <= '0;
            phase_lat_reg  <= '0;
            n_reg          <= '0;
            acc_reg        <= '0;
            armed_reg      <= 1'b0;
            seen_reg       <= 1'b0;
            done_reg       <= 1'b0;
            sum_reg        <= '0;
            pend_phase_reg <= '0;
            pend_seen_reg  <= 1'b0;
            period_reg     <= '0;
            phase_reg      <= '0;
            meas_valid_reg <= 1'b0;
            no_signal_reg  <= 1'b1;
            sig_lost_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            period_ctr_reg <= period_ctr_next;
            phase_ctr_reg  <= phase_ctr_next;
            phase_lat_reg  <= phase_lat_next;
            n_reg          <= n_next;
            acc_reg        <= acc_next;
            armed_reg      <= armed_next;
            seen_reg       <= seen_next;
            done_reg       <= done_next;
            sum_reg        <= sum_next;
            pend_phase_reg <= pend_phase_next;
            pend_seen_reg  <= pend_seen_next;
            period_reg     <= period_next;
            phase_reg      <= phase_next;
            meas_valid_reg <= meas_valid_next;
            no_signal_reg  <= no_signal_next;
            sig_lost_reg   <= sig_lost_next;
        end
    end

    assign period     = period_reg;
    assign phase      = phase_reg;
    assign meas_valid = meas_valid_reg;
    assign no_signal  = no_signal_reg;
    assign sig_lost   = sig_lost_reg;

endmodule

// File: tb/tb_pll_phase_meter.sv
// Self-checking bench for pll_phase_meter: table-driven windows plus hand-written
// timeout, phase-hold and mid-window reset sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_pll_phase_meter;

    localparam int CNT_W = 24;

    logic             clk_50;
    logic             rst_n;
    logic             ref_in;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] phase;
    logic             meas_valid;
    logic             no_signal;
    logic             sig_lost;

    pll_phase_meter #(
        .CNT_W       (CNT_W),
        .AVG_LOG2    (3),
        .TIMEOUT     (5000),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .ref_in     (ref_in),
        .sig_in     (sig_in),
        .period     (period),
        .phase      (phase),
        .meas_valid (meas_valid),
        .no_signal  (no_signal),
        .sig_lost   (sig_lost)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    typedef struct {
        int period;
        int phase;
        bit lost;
    } exp_t;

    typedef struct {
        int p_even;
        int p_odd;
        int p_last;
        int d;
        bit sig_en;
        bit glitch;
        int exp_period;
        int exp_phase;
        bit exp_lost;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   valid_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every result the DUT publishes must match the oldest pending expectation.
    always @(negedge clk_50) begin
        exp_t e;
        if (rst_n && meas_valid) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("period", period, e.period);
                check("phase", phase, e.phase);
                check("sig_lost", sig_lost, e.lost);
                check("no_signal_at_valid", no_signal, 0);
                $display("result: period=%0d phase=%0d sig_lost=%0b (expected %0d/%0d/%0b)",
                         period, phase, sig_lost, e.period, e.phase, e.lost);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int p, input int ph, input bit lost);
        exp_t e;
        e.period = p;
        e.phase  = ph;
        e.lost   = lost;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        rst_n  = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50);
    endtask

    // One reference period starting with a ref rise; sig rises d cycles later.
    task automatic drive_period(input int p, input int d, input bit sig_en, input bit glitch);
        for (int c = 0; c < p; c++) begin
            @(negedge clk_50);
            ref_in = (c < p / 2);
            sig_in = sig_en && ((c >= d && c < d + p / 4) ||
                                (glitch && c >= d + p / 4 + 5 && c < d + p / 4 + 10));
        end
    endtask

    function automatic int gap_len(input vec_t v, input int j);
        if (j == 7) return v.p_last;
        return (j % 2 == 1) ? v.p_odd : v.p_even;
    endfunction

    vec_t vecs[7];
    int   base_cnt;

    initial begin
        vecs[0] = '{200, 200, 200, 50, 1'b1, 1'b0, 200, 50, 1'b0};
        vecs[1] = '{199, 201, 201, 50, 1'b1, 1'b0, 200, 50, 1'b0};
        vecs[2] = '{201, 201, 201, 30, 1'b1, 1'b0, 201, 30, 1'b0};
        vecs[3] = '{200, 200, 207, 50, 1'b1, 1'b0, 200, 50, 1'b0};
        vecs[4] = '{200, 200, 200, 50, 1'b0, 1'b0, 200, 0, 1'b1};
        vecs[5] = '{200, 200, 200, 0, 1'b1, 1'b0, 200, 0, 1'b0};
        vecs[6] = '{200, 200, 200, 40, 1'b1, 1'b1, 200, 40, 1'b0};

        rst_n  = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_50);
        check("reset_period", period, 0);
        check("reset_phase", phase, 0);
        check("reset_meas_valid", meas_valid, 0);
        check("reset_no_signal", no_signal, 1);
        check("reset_sig_lost", sig_lost, 1);
        rst_n = 1'b1;

        // Two full windows per vector: 17 ref rises close windows at rises 9 and 17.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            push_exp(vecs[i].exp_period, vecs[i].exp_phase, vecs[i].exp_lost);
            push_exp(vecs[i].exp_period, vecs[i].exp_phase, vecs[i].exp_lost);
            for (int j = 0; j < 17; j++)
                drive_period(gap_len(vecs[i], j % 8), vecs[i].d, vecs[i].sig_en, vecs[i].glitch);
            check("vec_results_drained", sb_q.size(), 0);
            check("vec_no_signal", no_signal, 0);
        end

        // Sig disappears after lock: phase holds 50, sig_lost raised.
        do_reset();
        push_exp(200, 50, 1'b0);
        push_exp(200, 50, 1'b0);
        push_exp(200, 50, 1'b1);
        for (int j = 0; j < 16; j++) drive_period(200, 50, 1'b1, 1'b0);
        for (int j = 0; j < 9; j++)  drive_period(200, 50, 1'b0, 1'b0);
        check("hold_drained", sb_q.size(), 0);
        check("hold_phase", phase, 50);
        check("hold_sig_lost", sig_lost, 1);

        // Reference stops after lock: timeout roughly 5000 cycles after the last rise.
        do_reset();
        push_exp(200, 50, 1'b0);
        push_exp(200, 50, 1'b0);
        for (int j = 0; j < 17; j++) drive_period(200, 50, 1'b1, 1'b0);
        check("lock_no_signal", no_signal, 0);
        repeat (4795) @(negedge clk_50);
        check("before_timeout_no_signal", no_signal, 0);
        check("before_timeout_period", period, 200);
        repeat (15) @(negedge clk_50);
        check("timeout_no_signal", no_signal, 1);
        check("timeout_period", period, 0);
        check("timeout_sig_lost", sig_lost, 1);
        check("timeout_no_extra_valid", sb_q.size(), 0);
        push_exp(200, 50, 1'b0);
        base_cnt = valid_cnt;
        for (int j = 0; j < 8; j++) drive_period(200, 50, 1'b1, 1'b0);
        check("resume_no_early_valid", valid_cnt, base_cnt);
        drive_period(200, 50, 1'b1, 1'b0);
        check("resume_one_valid", valid_cnt, base_cnt + 1);
        check("resume_drained", sb_q.size(), 0);

        // Asynchronous reset in the middle of the second window.
        do_reset();
        push_exp(200, 60, 1'b0);
        for (int j = 0; j < 9; j++) drive_period(200, 60, 1'b1, 1'b0);
        check("prereset_period", period, 200);
        for (int j = 0; j < 4; j++) drive_period(200, 60, 1'b1, 1'b0);
        @(negedge clk_50);
        #3 rst_n = 1'b0;
        #2;
        check("async_rst_period", period, 0);
        check("async_rst_phase", phase, 0);
        check("async_rst_no_signal", no_signal, 1);
        check("async_rst_sig_lost", sig_lost, 1);
        check("async_rst_meas_valid", meas_valid, 0);
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        push_exp(200, 60, 1'b0);
        base_cnt = valid_cnt;
        for (int j = 0; j < 8; j++) drive_period(200, 60, 1'b1, 1'b0);
        check("post_rst_no_early_valid", valid_cnt, base_cnt);
        drive_period(200, 60, 1'b1, 1'b0);
        check("post_rst_one_valid", valid_cnt, base_cnt + 1);
        check("post_rst_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
